// File: rtl/apb_pkg.sv
// apb_pkg: shared APB widths, completer FSM states and wait-state limit
package apb_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int MAX_WAIT   = 15;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } apb_slv_state_e;

endpackage

// File: rtl/apb_wait_ctr.sv
// apb_wait_ctr: loadable down-counter; done_o flags the last wait cycle (count of 1)
module apb_wait_ctr
    import apb_pkg::*;
#(
    parameter int WIDTH = $clog2(MAX_WAIT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // load has priority; decrement saturates at zero
    always_comb begin
        cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end

    // count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/apb_wait_slave.sv
// apb_wait_slave: APB3 completer with DEPTH-word register bank and WAIT_CYCLES wait states.
// Optional macro APB_SLV_PROT_CHECK_EN: flag mid-transfer bus changes and answer them with pslverr.
module apb_wait_slave
    import apb_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int                  IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]          WAIT_V  = 4'(WAIT_CYCLES);

    apb_slv_state_e        state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  viol_q, viol_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic setup, in_err, range_err, viol_now, commit, ctr_done;

    assign setup     = (state_q == IDLE) && psel && !penable;
    assign in_err    = {1'b0, paddr} >= DEPTH_W;
    assign range_err = {1'b0, addr_q} >= DEPTH_W;

`ifdef APB_SLV_PROT_CHECK_EN
    assign viol_now = (state_q != IDLE) && psel &&
                      (paddr != addr_q || pwrite != write_q || pwdata != wdata_q || !penable);
`else
    assign viol_now = 1'b0;
`endif

    assign commit = (state_q == READY) && psel && penable && write_q &&
                    !range_err && !viol_q && !viol_now;

    apb_wait_ctr #(.WIDTH(4)) u_ctr (
        .clk_i      (pclk),
        .rst_ni     (presetn),
        .load_i     (setup),
        .en_i       ((state_q == WAIT) && psel),
        .load_val_i (WAIT_V),
        .done_o     (ctr_done)
    );

    // next-state: latch the request at setup, count waits, complete or abort back to IDLE
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        viol_d  = viol_q | viol_now;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    addr_d  = paddr;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    if (!pwrite) rdata_d = in_err ? '0 : mem_q[paddr[IW-1:0]];
                    state_d = (WAIT_V != 4'd0) ? WAIT : READY;
                end
            end
            WAIT:    state_d = !psel ? IDLE : ctr_done ? READY : WAIT;
            READY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) viol_d = 1'b0;
    end

    // control and latched-request registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            viol_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            viol_q  <= viol_d;
        end
    end

    // register bank, written only on an error-free completing write
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (commit) begin
            mem_q[addr_q[IW-1:0]] <= wdata_q;
        end
    end

    assign prdata  = rdata_q;
    assign pready  = (state_q == READY);
    assign pslverr = pready && (range_err || viol_q);

endmodule

// File: tb/tb_apb_wait_slave.sv
// tb_apb_wait_slave: scoreboard bench for apb_wait_slave (2-wait and 0-wait instances)
module tb_apb_wait_slave;
    import apb_pkg::*;

    typedef struct {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
        int                    cyc;
        logic                  rd;
    } exp_t;

    logic                  pclk = 1'b0;
    logic                  presetn;
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel2, psel0, penable, pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata2, prdata0;
    logic                  pready2, pready0, pslverr2, pslverr0;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 pclk = ~pclk;

    apb_wait_slave #(.DEPTH(16), .WAIT_CYCLES(2)) u_dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel2), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata2), .pready(pready2), .pslverr(pslverr2)
    );

    apb_wait_slave #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    // one APB transfer from setup to completion; returns observations only
    task automatic do_xfer(input bit w0, input logic wr, input logic [ADDR_WIDTH-1:0] a,
                           input logic [DATA_WIDTH-1:0] d, input bit chg,
                           input logic [ADDR_WIDTH-1:0] a2,
                           output logic [DATA_WIDTH-1:0] rd, output logic er, output int cyc);
        paddr = a; pwrite = wr; pwdata = d; penable = 1'b0;
        if (w0) psel0 = 1'b1; else psel2 = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b1;
        if (chg) paddr = a2;
        cyc = 1;
        while (!(w0 ? pready0 : pready2) && cyc < 20) begin
            @(posedge pclk); #1;
            cyc++;
        end
        cyc++;
        rd = w0 ? prdata0 : prdata2;
        er = w0 ? pslverr0 : pslverr2;
        @(posedge pclk); #1;
        psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({prdata2, pready2, pslverr2} !== {32'h0, 2'b00}) begin
            n_bad++;
            $display("FAIL reset_w2: got prdata=%h pready=%b pslverr=%b want 0/0/0", prdata2, pready2, pslverr2);
        end
        n_cmp++;
        if ({prdata0, pready0, pslverr0} !== {32'h0, 2'b00}) begin
            n_bad++;
            $display("FAIL reset_w0: got prdata=%h pready=%b pslverr=%b want 0/0/0", prdata0, pready0, pslverr0);
        end
    endtask

    task automatic test_out_of_range;
        logic [DATA_WIDTH-1:0] rd;
        logic er;
        int cy;
        exp_t e;
        for (int i = 0; i < 18; i++) begin
            if (i == 0) begin
                sb.push_back('{32'h0, 1'b1, 4, 1'b0});
                do_xfer(0, 1'b1, 8'd16, 32'hAA, 0, '0, rd, er, cy);
            end else begin
                sb.push_back('{32'h0, (i == 17), 4, 1'b1});
                do_xfer(0, 1'b0, (i == 17) ? 8'd16 : 8'(i - 1), '0, 0, '0, rd, er, cy);
            end
            e = sb.pop_front();
            n_cmp++;
            if (er !== e.err) begin n_bad++; $display("FAIL oor_err[%0d]: got %b want %b", i, er, e.err); end
            n_cmp++;
            if (cy != e.cyc) begin n_bad++; $display("FAIL oor_cycles[%0d]: got %0d want %0d", i, cy, e.cyc); end
            if (e.rd) begin
                n_cmp++;
                if (rd !== e.rdata) begin n_bad++; $display("FAIL oor_rdata[%0d]: got %h want %h", i, rd, e.rdata); end
            end
        end
    endtask

    task automatic test_write_read;
        logic [DATA_WIDTH-1:0] rd;
        logic er;
        int cy;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{32'hDEADBEEF, 1'b0, 4, (i == 1)});
            do_xfer(0, (i == 0), 8'd3, 32'hDEADBEEF, 0, '0, rd, er, cy);
            e = sb.pop_front();
            n_cmp++;
            if (er !== e.err) begin n_bad++; $display("FAIL wr_rd_err[%0d]: got %b want %b", i, er, e.err); end
            n_cmp++;
            if (cy != e.cyc) begin n_bad++; $display("FAIL wr_rd_cycles[%0d]: got %0d want %0d", i, cy, e.cyc); end
            if (e.rd) begin
                n_cmp++;
                if (rd !== e.rdata) begin n_bad++; $display("FAIL wr_rd_rdata: got %h want %h", rd, e.rdata); end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [DATA_WIDTH-1:0] rd;
        logic er;
        int cy;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{32'h11, 1'b0, 2, (i == 1)});
            do_xfer(1, (i == 0), 8'd0, 32'h11, 0, '0, rd, er, cy);
            e = sb.pop_front();
            n_cmp++;
            if (er !== e.err) begin n_bad++; $display("FAIL b2b_err[%0d]: got %b want %b", i, er, e.err); end
            n_cmp++;
            if (cy != e.cyc) begin n_bad++; $display("FAIL b2b_cycles[%0d]: got %0d want %0d", i, cy, e.cyc); end
            if (e.rd) begin
                n_cmp++;
                if (rd !== e.rdata) begin n_bad++; $display("FAIL b2b_rdata: got %h want %h", rd, e.rdata); end
            end
        end
    endtask

    task automatic test_abort;
        logic [DATA_WIDTH-1:0] rd;
        logic er;
        int cy;
        logic seen = 1'b0;
        exp_t e;
        paddr = 8'd2; pwrite = 1'b1; pwdata = 32'h55; penable = 1'b0; psel2 = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b1; psel2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge pclk); #1;
            seen |= pready2;
        end
        penable = 1'b0;
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_pready: got %b want 0", seen); end
        sb.push_back('{32'h0, 1'b0, 4, 1'b1});
        do_xfer(0, 1'b0, 8'd2, '0, 0, '0, rd, er, cy);
        e = sb.pop_front();
        n_cmp++;
        if (rd !== e.rdata) begin n_bad++; $display("FAIL abort_rdata: got %h want %h", rd, e.rdata); end
        n_cmp++;
        if (cy != e.cyc) begin n_bad++; $display("FAIL abort_cycles: got %0d want %0d", cy, e.cyc); end
    endtask

    task automatic test_prot;
        logic [DATA_WIDTH-1:0] rd;
        logic er;
        int cy;
        exp_t e;
`ifdef APB_SLV_PROT_CHECK_EN
        logic exp_err = 1'b1;
        logic [DATA_WIDTH-1:0] exp4 = 32'h0;
`else
        logic exp_err = 1'b0;
        logic [DATA_WIDTH-1:0] exp4 = 32'h77;
`endif
        sb.push_back('{32'h0, exp_err, 4, 1'b0});
        sb.push_back('{exp4, 1'b0, 4, 1'b1});
        sb.push_back('{32'h0, 1'b0, 4, 1'b1});
        for (int i = 0; i < 3; i++) begin
            if (i == 0) do_xfer(0, 1'b1, 8'd4, 32'h77, 1, 8'd5, rd, er, cy);
            else        do_xfer(0, 1'b0, 8'(3 + i), '0, 0, '0, rd, er, cy);
            e = sb.pop_front();
            n_cmp++;
            if (er !== e.err) begin n_bad++; $display("FAIL prot_err[%0d]: got %b want %b", i, er, e.err); end
            n_cmp++;
            if (cy != e.cyc) begin n_bad++; $display("FAIL prot_cycles[%0d]: got %0d want %0d", i, cy, e.cyc); end
            if (e.rd) begin
                n_cmp++;
                if (rd !== e.rdata) begin n_bad++; $display("FAIL prot_rdata[%0d]: got %h want %h", i, rd, e.rdata); end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [DATA_WIDTH-1:0] rd;
        logic er;
        int cy;
        exp_t e;
        sb.push_back('{32'h0, 1'b0, 4, 1'b0});
        sb.push_back('{32'h99, 1'b0, 4, 1'b1});
        do_xfer(0, 1'b1, 8'd5, 32'h99, 0, '0, rd, er, cy);
        e = sb.pop_front();
        n_cmp++;
        if (cy != e.cyc) begin n_bad++; $display("FAIL rst_pre_cycles: got %0d want %0d", cy, e.cyc); end
        do_xfer(0, 1'b0, 8'd5, '0, 0, '0, rd, er, cy);
        e = sb.pop_front();
        n_cmp++;
        if (rd !== e.rdata) begin n_bad++; $display("FAIL rst_pre_rdata: got %h want %h", rd, e.rdata); end
        paddr = 8'd5; pwrite = 1'b1; pwdata = 32'h123; penable = 1'b0; psel2 = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        presetn = 1'b0;
        #1;
        n_cmp++;
        if ({prdata2, pready2, pslverr2} !== {32'h0, 2'b00}) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got prdata=%h pready=%b pslverr=%b want 0/0/0", prdata2, pready2, pslverr2);
        end
        psel2 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        sb.push_back('{32'h0, 1'b0, 4, 1'b1});
        do_xfer(0, 1'b0, 8'd5, '0, 0, '0, rd, er, cy);
        e = sb.pop_front();
        n_cmp++;
        if (rd !== e.rdata) begin n_bad++; $display("FAIL rst_post_rdata: got %h want %h", rd, e.rdata); end
        n_cmp++;
        if (cy != e.cyc) begin n_bad++; $display("FAIL rst_post_cycles: got %0d want %0d", cy, e.cyc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        presetn = 1'b0; paddr = '0; psel2 = 1'b0; psel0 = 1'b0;
        penable = 1'b0; pwrite = 1'b0; pwdata = '0;
        repeat (2) @(posedge pclk);
        #1;
        test_reset();
        presetn = 1'b1;
        @(posedge pclk); #1;
        test_out_of_range();
        test_write_read();
        test_back_to_back();
        test_abort();
        test_prot();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_wait_slave.md
# apb_wait_slave

APB3 completer (responder) holding a DEPTH-word register bank and inserting a fixed, parameterised number of wait states before every completion. It sits on the slave side of the APB bus and is driven by `apb_master_top` through one of its `psel` lines. It returns `prdata`, `pready` and `pslverr` into the master's slave-interface struct. It is also the team's wait-state and error-response target for exercising the master's stall and error paths.

## Interface
Parameters:
- `DEPTH`, 16: number of 32-bit registers; valid word addresses are 0..DEPTH-1.
- `WAIT_CYCLES`, 2: wait cycles inserted between the setup cycle and the completing cycle, range 0..15.

Ports:
- `pclk`, input, 1: single clock; all state is updated on the rising edge.
- `presetn`, input, 1: asynchronous, active-low reset.
- `paddr`, input, `apb_pkg::ADDR_WIDTH`: word address.
- `psel`, input, 1: slave select.
- `penable`, input, 1: access phase.
- `pwrite`, input, 1: 1 = write, 0 = read.
- `pwdata`, input, `apb_pkg::DATA_WIDTH`: write data.
- `prdata`, output, `apb_pkg::DATA_WIDTH`: read data; registered.
- `pready`, output, 1: transfer completes this cycle.
- `pslverr`, output, 1: error response; meaningful only while `pready`=1.

## Operation
- FSM states: IDLE, WAIT, READY. All outputs decode from registered state only; there is no input-to-output combinational path.
- IDLE:
  - A setup cycle (`psel`=1, `penable`=0) latches `paddr`, `pwrite` and `pwdata`, and loads the counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise READY.
  - For reads, `prdata` is loaded at the setup edge with `reg[paddr]`, or 0 if `paddr`>=DEPTH.
- WAIT:
  - The counter decrements each cycle while `psel`=1.
  - When it reaches 1, the next state is READY.
- READY:
  - `pready`=1 and `pslverr` = (latched address >= DEPTH).
  - At the edge with `psel`=1 and `penable`=1, a write commits `reg[addr]` <= latched `pwdata`, unless `pslverr`=1.
  - The FSM then returns to IDLE.
- Out-of-range address: the write is discarded, `prdata`=0 and `pslverr`=1. It is never a hang.
- Master abort (`psel`=0 in WAIT or READY): return to IDLE with no write and no error.
- Back-to-back transfers: the cycle after a completion is IDLE and accepts a new setup immediately. A setup therefore cannot overlap a READY cycle.
- Reset mid-transfer: return immediately to IDLE; the pending write is lost; the register bank clears to 0.

## Timing
- Reset values:
  - `prdata`=0, `pready`=0, `pslverr`=0.
  - State is IDLE, the counter is 0, and all registers are 0.
- Setup cycle T0; wait cycles T1..T(WAIT_CYCLES); completion in cycle T(WAIT_CYCLES+1). A transfer takes WAIT_CYCLES+2 cycles in total.
- `pready` and `pslverr` are 0 in every cycle other than READY.
- `prdata` holds its value until the next read setup. Writes do not disturb it.
- With WAIT_CYCLES=0, `pready`=1 in the first access cycle, giving a zero-wait APB transfer of 2 cycles.
- Write data is visible to a read whose setup is in the cycle after the write completion.

## Configuration
- `APB_SLV_PROT_CHECK_EN` defined:
  - In WAIT or READY, `paddr`, `pwrite` or `pwdata` differing from the latched values, or `penable`=0 while `psel`=1, sets a sticky violation flag.
  - The transfer then completes on schedule with `pslverr`=1 and no write.
  - The flag clears on return to IDLE.
- `APB_SLV_PROT_CHECK_EN` not defined: changes to `paddr`, `pwrite` or `pwdata` after setup are ignored and the latched values are used. `pslverr` reflects the range error only.

## Structure
- `apb_pkg` holds:
  - ADDR_WIDTH and DATA_WIDTH;
  - the `apb_slv_state_e` enum (IDLE, WAIT, READY);
  - MAX_WAIT = 15.
- One sub-module, `apb_wait_ctr`: a loadable down-counter with a `done` output. It is reused by other wait-state targets.
- The register bank is a flop array in the top module; no SRAM macro is used.

## Test plan
- Write 0xDEADBEEF to address 3 with WAIT_CYCLES=2, then read address 3 → `pready` high in cycle T3 of each transfer; the read returns `prdata`=0xDEADBEEF; `pslverr`=0.
- WAIT_CYCLES=0, then back-to-back write 0x11 to address 0 and read address 0 → each transfer takes 2 cycles; the read returns 0x11; there is no idle gap.
- Write 0xAA to address 16 with DEPTH=16 → `pslverr`=1 with `pready`; a subsequent read of addresses 0..15 returns all zeros; a read of address 16 returns `prdata`=0 with `pslverr`=1.
- `psel` dropped in cycle T1 of a write of 0x55 to address 2 → FSM returns to IDLE; a read of address 2 returns 0.
- `presetn` asserted during WAIT of a write to address 5 → all outputs 0 immediately; after release, a read of address 5 returns 0.
- With `APB_SLV_PROT_CHECK_EN`, `paddr` changed from 4 to 5 in cycle T1 of a write of 0x77 → completion with `pslverr`=1; reads of addresses 4 and 5 return 0. Without the macro → 0x77 is written to address 4.
